// File: rtl/mem_req_queue_if.sv
// Handshake bundle between the agen latch, the memory-request queue and the LSU request port.
// The queue uses the slave modport; the surrounding pipe and LSU drive the master side.
interface mem_req_queue_if #(
  parameter int DEPTH = 4,
  parameter int PKT_W = 128
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush_i;
  logic             memValid_i;
  logic [PKT_W-1:0] memPacket_i;
  logic             memReady_o;
  logic             almostFull_o;
  logic             lsuValid_o;
  logic [PKT_W-1:0] lsuPacket_o;
  logic             lsuReady_i;
  logic [CNT_W-1:0] count_o;
  logic             overflow_o;

  modport slave (
    input  flush_i, memValid_i, memPacket_i, lsuReady_i,
    output memReady_o, almostFull_o, lsuValid_o, lsuPacket_o, count_o, overflow_o
  );

  modport master (
    output flush_i, memValid_i, memPacket_i, lsuReady_i,
    input  memReady_o, almostFull_o, lsuValid_o, lsuPacket_o, count_o, overflow_o
  );
endinterface

// File: rtl/mem_req_queue.sv
// Circular request queue absorbing LSU back-pressure for the non-stalling load/store pipe.
// Optional MEMQ_BYPASS_EN forwards a request straight to the LSU when the queue is empty.

module mem_req_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             reset,
  input logic             flush,
  input logic             push,
  input logic             memReady,
  input logic             lsuValid,
  input logic             lsuPacketZero,
  input logic [CNT_W-1:0] count
);
  a_countBound: assert property (@(posedge clk) disable iff (reset)
    count <= CNT_W'(DEPTH));

  a_readyMatch: assert property (@(posedge clk) disable iff (reset)
    memReady == (count != CNT_W'(DEPTH)));

  a_idleZero: assert property (@(posedge clk) disable iff (reset)
    !lsuValid |-> lsuPacketZero);

  a_flushClears: assert property (@(posedge clk) disable iff (reset)
    flush |=> (count == {CNT_W{1'b0}}));

  a_noPushFull: assert property (@(posedge clk) disable iff (reset)
    push |-> memReady);
endmodule

module mem_req_queue #(
  parameter int DEPTH     = 4,
  parameter int PKT_W     = 128,
  parameter int AF_MARGIN = 2
) (
  input logic            clk,
  input logic            reset,
  mem_req_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PKT_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] headPtr_r;
  logic [PTR_W-1:0] tailPtr_r;
  logic [CNT_W-1:0] count_r;
  logic             overflow_r;

  logic             headValid_s;
  logic             memReady_s;
  logic             push_s;
  logic             pop_s;
  logic             lsuValid_s;
  logic [PKT_W-1:0] lsuPacket_s;
  logic             bypassShow_s;
  logic             bypassTake_s;

  assign headValid_s = (count_r != {CNT_W{1'b0}});
  assign memReady_s  = (count_r != CNT_W'(DEPTH));

  // Bypass qualification: an empty queue presents the incoming request directly.
  always_comb begin
    bypassShow_s = 1'b0;
    bypassTake_s = 1'b0;
`ifdef MEMQ_BYPASS_EN
    if (!headValid_s && q.memValid_i && !q.flush_i) begin
      bypassShow_s = 1'b1;
      bypassTake_s = q.lsuReady_i;
    end else begin
      bypassShow_s = 1'b0;
      bypassTake_s = 1'b0;
    end
`endif
  end

  // Handshake qualification; a request consumed through the bypass is never written.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (q.memValid_i && memReady_s && !bypassTake_s) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (headValid_s && q.lsuReady_i) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Head presentation: zero when nothing is valid, so the LSU never sees stale storage.
  always_comb begin
    lsuValid_s  = 1'b0;
    lsuPacket_s = {PKT_W{1'b0}};
    if (headValid_s) begin
      lsuValid_s  = 1'b1;
      lsuPacket_s = mem_r[headPtr_r];
    end else if (bypassShow_s) begin
      lsuValid_s  = 1'b1;
      lsuPacket_s = q.memPacket_i;
    end else begin
      lsuValid_s  = 1'b0;
      lsuPacket_s = {PKT_W{1'b0}};
    end
  end

  // Storage write; contents are left untouched by reset and flush.
  always_ff @(posedge clk) begin
    if (push_s && !q.flush_i) begin
      mem_r[tailPtr_r] <= q.memPacket_i;
    end
  end

  // Pointer and occupancy state; flush outranks any same-cycle push or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headPtr_r <= {PTR_W{1'b0}};
      tailPtr_r <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
    end else if (q.flush_i) begin
      headPtr_r <= {PTR_W{1'b0}};
      tailPtr_r <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        tailPtr_r <= tailPtr_r + PTR_W'(1);
      end
      if (pop_s) begin
        headPtr_r <= headPtr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow flag; only reset clears it, flush leaves it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (q.memValid_i && !memReady_s) begin
      overflow_r <= 1'b1;
    end
  end

  assign q.memReady_o   = memReady_s;
  assign q.almostFull_o = (count_r >= CNT_W'(DEPTH - AF_MARGIN));
  assign q.lsuValid_o   = lsuValid_s;
  assign q.lsuPacket_o  = lsuPacket_s;
  assign q.count_o      = count_r;
  assign q.overflow_o   = overflow_r;

  mem_req_queue_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk           (clk),
    .reset         (reset),
    .flush         (q.flush_i),
    .push          (push_s),
    .memReady      (memReady_s),
    .lsuValid      (lsuValid_s),
    .lsuPacketZero (lsuPacket_s == {PKT_W{1'b0}}),
    .count         (count_r)
  );
endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue: a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_mem_req_queue;
  localparam int DEPTH = 4;
  localparam int PKT_W = 128;
`ifdef MEMQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_req_queue_if #(.DEPTH(DEPTH), .PKT_W(PKT_W)) bus ();

  mem_req_queue #(.DEPTH(DEPTH), .PKT_W(PKT_W), .AF_MARGIN(2)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus)
  );

  int vecCount  = 0;
  int missCount = 0;

  logic [PKT_W-1:0] mq [$];
  bit               ovf = 1'b0;
  logic [PKT_W-1:0] pk [0:19];

  task automatic chk(input string nm, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [PKT_W-1:0] p, input bit r, input bit f);
    bus.memValid_i  = v;
    bus.memPacket_i = p;
    bus.lsuReady_i  = r;
    bus.flush_i     = f;
  endtask

  task automatic cyc(input bit v, input logic [PKT_W-1:0] p, input bit r, input bit f);
    drive(v, p, r, f);
    @(posedge clk);
    #1;
  endtask

  // Reference model: FIFO occupancy as a queue, updated by the handshake rules.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      ovf = 1'b0;
    end else begin
      int  sz;
      bit  full;
      bit  take;
      sz   = mq.size();
      full = (sz == DEPTH);
      if (bus.memValid_i && full) ovf = 1'b1;
      if (bus.flush_i) begin
        mq.delete();
      end else begin
        take = BYP && (sz == 0) && bus.memValid_i && bus.lsuReady_i;
        if (sz != 0 && bus.lsuReady_i) void'(mq.pop_front());
        if (bus.memValid_i && !full && !take) mq.push_back(bus.memPacket_i);
      end
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      int               sz;
      bit               show;
      logic [PKT_W-1:0] expPkt;
      sz   = mq.size();
      show = BYP && (sz == 0) && bus.memValid_i && !bus.flush_i;
      if (sz != 0) expPkt = mq[0];
      else if (show) expPkt = bus.memPacket_i;
      else expPkt = '0;
      chk("mdl_valid",  PKT_W'(bus.lsuValid_o),   PKT_W'((sz != 0) || show));
      chk("mdl_packet", bus.lsuPacket_o,          expPkt);
      chk("mdl_count",  PKT_W'(bus.count_o),      PKT_W'(sz));
      chk("mdl_ready",  PKT_W'(bus.memReady_o),   PKT_W'(sz != DEPTH));
      chk("mdl_afull",  PKT_W'(bus.almostFull_o), PKT_W'(sz >= DEPTH - 2));
      chk("mdl_ovf",    PKT_W'(bus.overflow_o),   PKT_W'(ovf));
    end
  end

  initial begin
    logic [3:0] afTab;
    logic [3:0] rdyTab;
    afTab  = 4'b1110;
    rdyTab = 4'b0111;
    for (int i = 0; i < 20; i++) pk[i] = {4{32'hA5A5_0000 + 32'(i)}};

    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_ready", PKT_W'(bus.memReady_o),   PKT_W'(1));
    chk("rst_valid", PKT_W'(bus.lsuValid_o),   PKT_W'(0));
    chk("rst_count", PKT_W'(bus.count_o),      PKT_W'(0));
    chk("rst_afull", PKT_W'(bus.almostFull_o), PKT_W'(0));
    chk("rst_ovf",   PKT_W'(bus.overflow_o),   PKT_W'(0));
    chk("rst_pkt",   bus.lsuPacket_o,          '0);

    // Fill A..D with the LSU stalled
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, pk[i], 1'b0, 1'b0);
      chk("fill_count", PKT_W'(bus.count_o),      PKT_W'(i + 1));
      chk("fill_afull", PKT_W'(bus.almostFull_o), PKT_W'(afTab[i]));
      chk("fill_ready", PKT_W'(bus.memReady_o),   PKT_W'(rdyTab[i]));
    end
    chk("fill_head", bus.lsuPacket_o, pk[0]);

    // Full queue: push E together with a pop; E is dropped
    cyc(1'b1, pk[4], 1'b1, 1'b0);
    chk("drop_count", PKT_W'(bus.count_o),    PKT_W'(3));
    chk("drop_ovf",   PKT_W'(bus.overflow_o), PKT_W'(1));
    chk("drop_head",  bus.lsuPacket_o,        pk[1]);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("ovf_sticky", PKT_W'(bus.overflow_o), PKT_W'(1));

    for (int i = 1; i < 4; i++) begin
      chk("drain_head", bus.lsuPacket_o, pk[i]);
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    chk("empty_valid", PKT_W'(bus.lsuValid_o), PKT_W'(0));
    chk("empty_pkt",   bus.lsuPacket_o,        '0);
    chk("empty_count", PKT_W'(bus.count_o),    PKT_W'(0));

    // Wrap-around at steady occupancy 2
    cyc(1'b1, pk[5], 1'b0, 1'b0);
    cyc(1'b1, pk[6], 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("wrap_head", bus.lsuPacket_o, pk[5 + i]);
      cyc(1'b1, pk[7 + i], 1'b1, 1'b0);
      chk("wrap_count", PKT_W'(bus.count_o), PKT_W'(2));
    end

    // Flush at occupancy 3 with a simultaneous push and pop
    cyc(1'b1, pk[17], 1'b0, 1'b0);
    chk("pre_flush_count", PKT_W'(bus.count_o), PKT_W'(3));
    cyc(1'b1, pk[18], 1'b1, 1'b1);
    chk("flush_count", PKT_W'(bus.count_o),    PKT_W'(0));
    chk("flush_valid", PKT_W'(bus.lsuValid_o), PKT_W'(0));
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("flush_nostore", PKT_W'(bus.lsuValid_o), PKT_W'(0));
    chk("flush_ovf",     PKT_W'(bus.overflow_o), PKT_W'(1));

    // Empty queue, 0x5A offered with the LSU ready
    drive(1'b1, PKT_W'(8'h5A), 1'b1, 1'b0);
    #1;
    chk("byp_valid_same", PKT_W'(bus.lsuValid_o), PKT_W'(BYP));
    chk("byp_pkt_same",   bus.lsuPacket_o,        BYP ? PKT_W'(8'h5A) : '0);
    @(posedge clk);
    #1;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("byp_count_next", PKT_W'(bus.count_o),    PKT_W'(!BYP));
    chk("byp_valid_next", PKT_W'(bus.lsuValid_o), PKT_W'(!BYP));
    chk("byp_pkt_next",   bus.lsuPacket_o,        BYP ? '0 : PKT_W'(8'h5A));
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("byp_drained", PKT_W'(bus.count_o), PKT_W'(0));

    // Asynchronous reset in the middle of a cycle
    cyc(1'b1, pk[19], 1'b0, 1'b0);
    cyc(1'b1, pk[0], 1'b0, 1'b0);
    chk("mid_count_pre", PKT_W'(bus.count_o), PKT_W'(2));
    drive(1'b0, '0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mid_count", PKT_W'(bus.count_o),    PKT_W'(0));
    chk("mid_valid", PKT_W'(bus.lsuValid_o), PKT_W'(0));
    chk("mid_ovf",   PKT_W'(bus.overflow_o), PKT_W'(0));
    chk("mid_ready", PKT_W'(bus.memReady_o), PKT_W'(1));
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(1'b1, pk[9], 1'b0, 1'b0);
    chk("post_rst_head", bus.lsuPacket_o, pk[9]);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
